score_display: RTL



---
 rtl/score_display.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/score_display.sv
// -----------------------------------------------------------------------------
// score_display
//
// Takes the 32-bit running score from the score engine, converts it to BCD
// with a sequential double-dabble engine, and scans the result onto a
// time-multiplexed, active-low seven-segment display with leading-zero
// blanking. Lives in the clock_div domain next to the score engine.
//
// Optional feature (macro SCORE_DISPLAY_HIGH_SCORE_EN):
//   Keeps a high-score register that is updated on each isdead rising edge,
//   and lets show_high route that register into the converter instead of
//   the live score (also while isdead is high, for the death screen).
//
// Parameters:
//   DIGITS        number of displayed decimal digits (1..8); the converted
//                 value saturates at 10^DIGITS-1
//   REFRESH_BITS  width of the free-running refresh counter; the scanned
//                 digit advances each time it wraps
//
// Ports:
//   clock_div   in   1         clock
//   reset_n     in   1         asynchronous active-low reset
//   score       in   32        binary score
//   isdead      in   1         player dead; no new conversions start while high
//   show_high   in   1         (optional) convert high_score instead of score
//   high_score  out  32        (optional) highest score seen at a death
//   seg         out  7         segments, active-low, seg[0]=a .. seg[6]=g
//   an          out  DIGITS    digit enables, active-low one-hot, an[0]=units
//   dp          out  1         decimal point, active-low, always off
//   bcd         out  4*DIGITS  BCD of the last completed conversion
//   bcd_valid   out  1         one-cycle pulse when bcd updates
//
// FSM states:
//   state   | meaning
//   S_IDLE  | waiting; start a conversion when allowed
//   S_LOAD  | sample (and saturate) the source, clear the BCD accumulator
//   S_SHIFT | 32 add-3/shift iterations of double-dabble
//   S_DONE  | publish the low DIGITS nibbles to bcd, pulse bcd_valid
// -----------------------------------------------------------------------------
module score_display #(
  parameter int DIGITS       = 8,
  parameter int REFRESH_BITS = 16
) (
  input  logic                clock_div,
  input  logic                reset_n,
  input  logic [31:0]         score,
  input  logic                isdead,
`ifdef SCORE_DISPLAY_HIGH_SCORE_EN
  input  logic                show_high,
  output logic [31:0]         high_score,
`endif
  output logic [6:0]          seg,
  output logic [DIGITS-1:0]   an,
  output logic                dp,
  output logic [4*DIGITS-1:0] bcd,
  output logic                bcd_valid
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic logic [31:0] f_max_score(input int n);
    logic [31:0] v;
    v = 32'd1;
    for (int k = 0; k < n; k++) begin
      v = v * 32'd10;
    end
    return v - 32'd1;
  endfunction

  localparam logic [31:0] MAX_SCORE = f_max_score(DIGITS);

  // Segment patterns, active-low, bit order g..a.
  function automatic logic [6:0] f_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [31:0]               r_bin;
  logic [39:0]               r_acc;
  logic [39:0]               w_acc_adj;
  logic [4:0]                r_bitcnt;
  logic [4*DIGITS-1:0]       r_bcd;
  logic                      r_bcd_valid;
  logic                      w_start;
  logic [31:0]               w_sample;
  logic [31:0]               w_sample_sat;
  logic                      w_unused_acc_msb;

  logic [REFRESH_BITS-1:0]   r_refresh_cnt;
  logic                      w_wrap;
  logic [IDX_W-1:0]          r_digit_idx;
  logic [3:0]                w_nibble;
  logic                      w_blank;
  logic [6:0]                r_seg;
  logic [DIGITS-1:0]         r_an;

`ifdef SCORE_DISPLAY_HIGH_SCORE_EN
  logic [31:0]               r_high_score;
  logic                      r_isdead_d;

  // The high-score view may be converted on the death screen, so show_high
  // overrides the isdead hold.
  assign w_start  = ~isdead | show_high;
  assign w_sample = show_high ? r_high_score : score;

  always_ff @(posedge clock_div or negedge reset_n) begin
    if (!reset_n) begin
      r_isdead_d   <= 1'b0;
      r_high_score <= 32'd0;
    end else begin
      r_isdead_d <= isdead;
      if (isdead && !r_isdead_d && (score > r_high_score)) begin
        r_high_score <= score;
      end
    end
  end

  assign high_score = r_high_score;
`else
  assign w_start  = ~isdead;
  assign w_sample = score;
`endif

  assign w_sample_sat = (w_sample > MAX_SCORE) ? MAX_SCORE : w_sample;

  // ---------------------------------------------------------------------------
  // Conversion FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_div or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_SHIFT;
      S_SHIFT: if (r_bitcnt == 5'd31) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Add-3 correction on every nibble (4-bit adds, no inter-nibble carry).
  always_comb begin
    w_acc_adj = r_acc;
    for (int n = 0; n < 10; n++) begin
      if (r_acc[4*n +: 4] >= 4'd5) begin
        w_acc_adj[4*n +: 4] = r_acc[4*n +: 4] + 4'd3;
      end
    end
  end

  // The accumulator MSB is shifted out; with saturated inputs it stays zero.
  assign w_unused_acc_msb = w_acc_adj[39];

  always_ff @(posedge clock_div or negedge reset_n) begin
    if (!reset_n) begin
      r_bin       <= 32'd0;
      r_acc       <= 40'd0;
      r_bitcnt    <= 5'd0;
      r_bcd       <= '0;
      r_bcd_valid <= 1'b0;
    end else begin
      r_bcd_valid <= 1'b0;
      case (r_state)
        S_LOAD: begin
          r_bin    <= w_sample_sat;
          r_acc    <= 40'd0;
          r_bitcnt <= 5'd0;
        end
        S_SHIFT: begin
          r_acc    <= {w_acc_adj[38:0], r_bin[31]};
          r_bin    <= {r_bin[30:0], 1'b0};
          r_bitcnt <= r_bitcnt + 5'd1;
        end
        S_DONE: begin
          r_bcd       <= r_acc[4*DIGITS-1:0];
          r_bcd_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Display refresh
  // ---------------------------------------------------------------------------
  assign w_wrap = (r_refresh_cnt == {REFRESH_BITS{1'b1}});

  // Pick the nibble for the current digit and decide blanking: a digit above
  // the units is blank when it and every digit above it are zero.
  always_comb begin
    logic l_nz;
    w_nibble = 4'd0;
    w_blank  = 1'b0;
    l_nz     = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      l_nz = l_nz | (|r_bcd[4*i +: 4]);
      if (r_digit_idx == IDX_W'(i)) begin
        w_nibble = r_bcd[4*i +: 4];
        w_blank  = (i != 0) && !l_nz;
      end
    end
  end

  // Outputs are loaded on the wrap for the digit index current at that wrap,
  // so the first refresh after reset presents digit 0.
  always_ff @(posedge clock_div or negedge reset_n) begin
    if (!reset_n) begin
      r_refresh_cnt <= '0;
      r_digit_idx   <= '0;
      r_seg         <= 7'h7F;
      r_an          <= '1;
    end else begin
      r_refresh_cnt <= r_refresh_cnt + REFRESH_BITS'(1);
      if (w_wrap) begin
        r_an  <= ~(DIGITS'(1) << r_digit_idx);
        r_seg <= w_blank ? 7'h7F : f_seg(w_nibble);
        if (r_digit_idx == IDX_W'(DIGITS - 1)) begin
          r_digit_idx <= '0;
        end else begin
          r_digit_idx <= r_digit_idx + IDX_W'(1);
        end
      end
    end
  end

  assign seg       = r_seg;
  assign an        = r_an;
  assign dp        = 1'b1;
  assign bcd       = r_bcd;
  assign bcd_valid = r_bcd_valid;

endmodule
